// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer: FSM state codes,
// redirect priorities and the default exception vector.
package pc_seq_pkg;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;
    localparam logic [1:0] ST_STEP = 2'd3;

    // Numeric order is the arbitration order: larger value wins.
    typedef enum logic [2:0] {
        PRI_SEQ  = 3'd0,
        PRI_BR   = 3'd1,
        PRI_JMP  = 3'd2,
        PRI_ERET = 3'd3,
        PRI_EXC  = 3'd4
    } redir_pri_e;

    typedef struct packed {
        logic       vld;
        redir_pri_e pri;
        logic [31:0] tgt;
    } redir_t;

    localparam logic [31:0] EXC_VEC_DEFAULT = 32'h0000_0180;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of the hazard/branch/CP0 inputs and PC-register outputs of pc_sequencer.
interface pc_sequencer_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      pc_4;
    logic             stall;
    logic             br_taken;
    logic [31:0]      br_target;
    logic             jmp;
    logic [31:0]      jmp_target;
    logic             exc_req;
    logic             eret;
    logic [31:0]      epc;
    logic             halt_req;
    logic             dbg_run;
    logic             dbg_step;
    logic             pc_en;
    logic [31:0]      pc_new;
    logic             flush;
    logic             exc_ack;
    logic             halted;
    logic [CNT_W-1:0] fetch_cnt;

    modport master (
        output pc_4, stall, br_taken, br_target, jmp, jmp_target,
               exc_req, eret, epc, halt_req, dbg_run, dbg_step,
        input  pc_en, pc_new, flush, exc_ack, halted, fetch_cnt
    );

    modport slave (
        input  pc_4, stall, br_taken, br_target, jmp, jmp_target,
               exc_req, eret, epc, halt_req, dbg_run, dbg_step,
        output pc_en, pc_new, flush, exc_ack, halted, fetch_cnt
    );

endinterface

// File: rtl/pc_redirect_sel.sv
// Combinational arbiter: picks the strongest live redirect, then merges it
// with the pending one (live wins ties).
module pc_redirect_sel
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEFAULT
) (
    input  logic        live_en,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  redir_t      pend,
    output redir_t      sel
);

    redir_t live;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        live = '{vld: 1'b0, pri: PRI_SEQ, tgt: 32'h0};
        if (live_en) begin
            if (exc_req) begin
                live = '{vld: 1'b1, pri: PRI_EXC, tgt: EXC_VEC};
            end else if (eret) begin
                live = '{vld: 1'b1, pri: PRI_ERET, tgt: epc};
            end else if (jmp) begin
                live = '{vld: 1'b1, pri: PRI_JMP, tgt: jmp_target};
            end else if (br_taken) begin
                live = '{vld: 1'b1, pri: PRI_BR, tgt: br_target};
            end
        end

        sel = live;
        if (pend.vld && (!live.vld || (pend.pri > live.pri))) begin
            sel = pend;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC-register controller: boot delay, run/halt/step FSM, pending-redirect
// register and retired-fetch counter around the redirect arbiter.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] EXC_VEC     = EXC_VEC_DEFAULT,
    parameter int          BOOT_CYCLES = 2,
    parameter int          CNT_W       = 32
) (
    input logic           clk,
    input logic           rst_n,
    pc_sequencer_if.slave bus
);

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       boot_cnt_q, boot_cnt_d;
    redir_t           pend_q, pend_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;

    logic   booting;
    logic   pc_en;
    redir_t sel;

    assign booting = (state_q == ST_BOOT);
    assign pc_en   = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !bus.stall;

    // Live requests are invisible during boot, so the pending slot stays empty there.
    pc_redirect_sel #(
        .EXC_VEC (EXC_VEC)
    ) u_sel (
        .live_en    (!booting),
        .exc_req    (bus.exc_req),
        .eret       (bus.eret),
        .epc        (bus.epc),
        .jmp        (bus.jmp),
        .jmp_target (bus.jmp_target),
        .br_taken   (bus.br_taken),
        .br_target  (bus.br_target),
        .pend       (pend_q),
        .sel        (sel)
    );

    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        pend_d      = pend_q;
        fetch_cnt_d = fetch_cnt_q + CNT_W'(pc_en);

        case (state_q)
            ST_BOOT: begin
                if (boot_cnt_q == BOOT_LAST) state_d = ST_RUN;
                else                         boot_cnt_d = boot_cnt_q + 4'd1;
            end
            ST_RUN:  if (bus.halt_req) state_d = ST_HALT;
            ST_HALT: begin
                if (bus.dbg_run)       state_d = ST_RUN;
                else if (bus.dbg_step) state_d = ST_STEP;
            end
            ST_STEP: if (pc_en) state_d = ST_HALT;
            default: state_d = ST_BOOT;
        endcase

        // The merged selection already encodes the replace-if-not-weaker rule,
        // so capturing it while the PC holds doubles as the pending update.
        if (pc_en) begin
            pend_d = '0;
        end else if (!booting) begin
            pend_d = sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BOOT;
            boot_cnt_q  <= 4'd0;
            pend_q      <= '0;
            fetch_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            pend_q      <= pend_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign bus.pc_en     = pc_en;
    assign bus.pc_new    = sel.vld ? sel.tgt : bus.pc_4;
    assign bus.flush     = pc_en && sel.vld;
    assign bus.exc_ack   = bus.exc_req && !booting;
    assign bus.halted    = (state_q == ST_HALT);
    assign bus.fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, reset corner
// sequence, then randomized traffic against a behavioural reference model.
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pc_sequencer_if #(.CNT_W(32)) bus ();

    pc_sequencer #(
        .EXC_VEC     (32'h0000_0180),
        .BOOT_CYCLES (2),
        .CNT_W       (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Control bits of a vector: {stall, br, jmp, exc, eret, halt, run, step}
    localparam logic [7:0] ST = 8'h80, BR = 8'h40, JP = 8'h20, EX = 8'h10;
    localparam logic [7:0] ER = 8'h08, HT = 8'h04, RN = 8'h02, SP = 8'h01;
    // Expected flags: {pc_en, flush, exc_ack, halted}
    localparam logic [3:0] O_EN = 4'b1000, O_FL = 4'b0100, O_AK = 4'b0010, O_HL = 4'b0001;
    localparam int NC = 0, P4 = 1, VAL = 2;

    typedef struct {
        logic [7:0]  ctl;
        logic [31:0] tgt;
        logic [3:0]  outs;
        int          cnt;
        int          nsel;
        logic [31:0] exp_new;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic [7:0] ctl, input logic [31:0] tgt, input logic [3:0] outs,
                       input int cnt, input int nsel, input logic [31:0] exp_new);
        vec_t v;
        v = '{ctl, tgt, outs, cnt, nsel, exp_new};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [7:0] ctl, input logic [31:0] tgt, input logic [31:0] pc4);
        bus.stall      = ctl[7];
        bus.br_taken   = ctl[6];
        bus.jmp        = ctl[5];
        bus.exc_req    = ctl[4];
        bus.eret       = ctl[3];
        bus.halt_req   = ctl[2];
        bus.dbg_run    = ctl[1];
        bus.dbg_step   = ctl[0];
        bus.br_target  = tgt;
        bus.jmp_target = tgt;
        bus.epc        = tgt;
        bus.pc_4       = pc4;
    endtask

    // Reference model state
    typedef struct { int pri; logic [31:0] tgt; } red_t;
    int          boot_left;
    bit          in_halt, step_armed;
    red_t        m_pend[$];
    logic [31:0] m_cnt;

    initial begin
        // boot, exception-over-branch, stalled jump
        row(0,       0,        0,                 0,  P4,  0);
        row(EX,      0,        0,                 0,  P4,  0);
        row(0,       0,        O_EN,              0,  P4,  0);
        row(0,       0,        O_EN,              1,  P4,  0);
        row(BR|EX,   32'h40,   O_EN|O_FL|O_AK,    2,  VAL, 32'h180);
        row(ST|JP,   32'h100,  0,                 3,  NC,  0);
        row(ST,      0,        0,                 3,  NC,  0);
        row(ST,      0,        0,                 3,  NC,  0);
        row(0,       0,        O_EN|O_FL,         3,  VAL, 32'h100);
        row(0,       0,        O_EN,              4,  P4,  0);
        // pending arbitration against weaker, stronger and equal newcomers
        row(ST|JP,   32'h100,  0,                 5,  NC,  0);
        row(ST|BR,   32'h80,   0,                 5,  NC,  0);
        row(0,       0,        O_EN|O_FL,         5,  VAL, 32'h100);
        row(ST|JP,   32'h100,  0,                 6,  NC,  0);
        row(ST|ER,   32'h200,  0,                 6,  NC,  0);
        row(0,       0,        O_EN|O_FL,         6,  VAL, 32'h200);
        row(ST|BR,   32'h80,   0,                 7,  NC,  0);
        row(JP,      32'h300,  O_EN|O_FL,         7,  VAL, 32'h300);
        row(ST|JP,   32'h100,  0,                 8,  NC,  0);
        row(BR,      32'h44,   O_EN|O_FL,         8,  VAL, 32'h100);
        row(ST|JP,   32'h100,  0,                 9,  NC,  0);
        row(JP,      32'h500,  O_EN|O_FL,         9,  VAL, 32'h500);
        row(ST|EX,   0,        O_AK,              10, NC,  0);
        row(0,       0,        O_EN|O_FL,         10, VAL, 32'h180);
        // halt, stalled single step, run (run beats step)
        row(HT,      0,        O_EN,              11, P4,  0);
        row(0,       0,        O_HL,              12, NC,  0);
        row(ST,      0,        O_HL,              12, NC,  0);
        row(ST|SP,   0,        O_HL,              12, NC,  0);
        row(ST,      0,        0,                 12, NC,  0);
        row(0,       0,        O_EN,              12, P4,  0);
        row(0,       0,        O_HL,              13, NC,  0);
        row(RN|SP,   0,        O_HL,              13, NC,  0);
        row(0,       0,        O_EN,              13, P4,  0);
        row(0,       0,        O_EN,              14, P4,  0);
        // halt while stalled keeps the pending jump for the next step
        row(ST|JP|HT, 32'h600, 0,                 15, NC,  0);
        row(0,       0,        O_HL,              15, NC,  0);
        row(SP,      0,        O_HL,              15, NC,  0);
        row(0,       0,        O_EN|O_FL,         15, VAL, 32'h600);
        row(0,       0,        O_HL,              16, NC,  0);
        row(ST|JP,   32'h700,  O_HL,              16, NC,  0);

        rst_n = 1'b0;
        drive(0, 0, 32'h2000);
        #12;
        check("rst pc_en",     32'(bus.pc_en),   0);
        check("rst flush",     32'(bus.flush),   0);
        check("rst exc_ack",   32'(bus.exc_ack), 0);
        check("rst halted",    32'(bus.halted),  0);
        check("rst pc_new",    bus.pc_new,       32'h2000);
        check("rst fetch_cnt", bus.fetch_cnt,    0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            logic [31:0] pc4;
            pc4 = 32'h1000 + 32'(i * 4);
            drive(vecs[i].ctl, vecs[i].tgt, pc4);
            @(negedge clk);
            check($sformatf("v%0d pc_en", i),     32'(bus.pc_en),   32'(vecs[i].outs[3]));
            check($sformatf("v%0d flush", i),     32'(bus.flush),   32'(vecs[i].outs[2]));
            check($sformatf("v%0d exc_ack", i),   32'(bus.exc_ack), 32'(vecs[i].outs[1]));
            check($sformatf("v%0d halted", i),    32'(bus.halted),  32'(vecs[i].outs[0]));
            check($sformatf("v%0d fetch_cnt", i), bus.fetch_cnt,    32'(vecs[i].cnt));
            if (vecs[i].nsel == P4)  check($sformatf("v%0d pc_new", i), bus.pc_new, pc4);
            if (vecs[i].nsel == VAL) check($sformatf("v%0d pc_new", i), bus.pc_new, vecs[i].exp_new);
            @(posedge clk); #1;
        end

        // Asynchronous reset in HALT with a pending jump
        drive(0, 0, 32'h3000);
        rst_n = 1'b0;
        #1;
        check("mid rst pc_en",     32'(bus.pc_en),  0);
        check("mid rst halted",    32'(bus.halted), 0);
        check("mid rst fetch_cnt", bus.fetch_cnt,   0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("reboot%0d pc_en", c), 32'(bus.pc_en), (c == 2) ? 32'd1 : 32'd0);
            check($sformatf("reboot%0d flush", c), 32'(bus.flush), 0);
            check($sformatf("reboot%0d pc_new", c), bus.pc_new,    32'h3000);
            @(posedge clk); #1;
        end

        // Randomized traffic against the reference model
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        boot_left = 2; in_halt = 0; step_armed = 0; m_pend.delete(); m_cnt = 0;
        for (int n = 0; n < 1500; n++) begin
            bit active, e_en, e_fl, e_ack, e_hl, have;
            int lp;
            logic [31:0] ltgt;
            red_t c;

            bus.stall      = ($urandom % 10) < 3;
            bus.br_taken   = ($urandom % 6) == 0;
            bus.jmp        = ($urandom % 6) == 0;
            bus.exc_req    = ($urandom % 8) == 0;
            bus.eret       = ($urandom % 8) == 0;
            bus.halt_req   = ($urandom % 16) == 0;
            bus.dbg_run    = ($urandom % 8) == 0;
            bus.dbg_step   = ($urandom % 8) == 0;
            bus.br_target  = $urandom & 32'hFFFF_FFFC;
            bus.jmp_target = $urandom & 32'hFFFF_FFFC;
            bus.epc        = $urandom & 32'hFFFF_FFFC;
            bus.pc_4       = $urandom & 32'hFFFF_FFFC;

            active = (boot_left == 0) && (!in_halt || step_armed);
            e_en   = active && !bus.stall;
            lp = 0; ltgt = 0;
            if (boot_left == 0) begin
                if (bus.br_taken) begin lp = 1; ltgt = bus.br_target;  end
                if (bus.jmp)      begin lp = 2; ltgt = bus.jmp_target; end
                if (bus.eret)     begin lp = 3; ltgt = bus.epc;        end
                if (bus.exc_req)  begin lp = 4; ltgt = 32'h180;        end
            end
            have = 0; c = '{0, 32'h0};
            if (m_pend.size() > 0) begin have = 1; c = m_pend[0]; end
            if (lp > 0 && (!have || lp >= c.pri)) begin have = 1; c = '{lp, ltgt}; end
            e_fl  = e_en && have;
            e_ack = bus.exc_req && (boot_left == 0);
            e_hl  = in_halt && !step_armed;

            @(negedge clk);
            check("rnd pc_en",     32'(bus.pc_en),   32'(e_en));
            check("rnd flush",     32'(bus.flush),   32'(e_fl));
            check("rnd exc_ack",   32'(bus.exc_ack), 32'(e_ack));
            check("rnd halted",    32'(bus.halted),  32'(e_hl));
            check("rnd fetch_cnt", bus.fetch_cnt,    m_cnt);
            if (e_en || boot_left > 0)
                check("rnd pc_new", bus.pc_new, have ? c.tgt : bus.pc_4);

            if (boot_left > 0) begin
                boot_left--;
            end else begin
                if (e_en)      m_pend.delete();
                else if (have) begin m_pend.delete(); m_pend.push_back(c); end
                if (in_halt && step_armed) begin
                    if (e_en) step_armed = 0;
                end else if (in_halt) begin
                    if (bus.dbg_run)       in_halt = 0;
                    else if (bus.dbg_step) step_armed = 1;
                end else if (bus.halt_req) begin
                    in_halt = 1;
                end
            end
            if (e_en) m_cnt++;
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
